bcd_count_ctrl: RTL and testbench
=================================

# bcd_count_ctrl

Command-driven controller for a cascaded multi-digit BCD counter. It accepts CLEAR/LOAD/START/STOP commands over a valid/ready handshake and validates BCD operands. It sequences per-digit carry enables from an external count tick and signals completion when the count reaches a programmed terminal value. It is the sequencing layer above the single-digit 0–9 counter and replaces ad-hoc load/reset wiring between digits.

## Interface
- DIGITS, 4: number of BCD digits in the chain (1–8).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command this cycle.
- cmd_op  in  2  00 CLEAR, 01 LOAD, 10 START, 11 STOP.
- cmd_data  in  4*DIGITS  packed BCD operand, digit 0 in [3:0]; LOAD value or START terminal value.
- tick  in  1  single-cycle count-enable pulse.
- dir  in  1  count direction, 1 = down. Exists only when BCD_CTRL_DOWN_EN is defined.
- count  out  4*DIGITS  current packed BCD count.
- running  out  1  high in RUN state.
- done  out  1  one-cycle pulse on terminal reached.
- err  out  1  sticky; a command carried an illegal BCD digit.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: count 0, running 0, done 0, err 0, cmd_ready 1.
- cmd_ready = 1 in IDLE and RUN, 0 in DONE. A command is accepted on cmd_valid & cmd_ready.
- CLEAR: count ← 0, err ← 0, state ← IDLE. Accepted in any non-DONE state.
- LOAD: if every digit of cmd_data is ≤ 9, count ← cmd_data and state is unchanged, so RUN keeps running. If any digit is > 9, the command is dropped and err ← 1.
- START: if the operand is valid, term ← cmd_data and state ← RUN. If invalid, it is dropped, err ← 1, and the state is unchanged. START in RUN reprograms term and keeps running.
- STOP: RUN → IDLE with count held. In IDLE, STOP is a no-op.
- Counting in RUN on tick: digit 0 increments, and each digit increments when all lower digits are at 9. A digit at 9 wraps to 0. The full count 99…9 wraps to 00…0 and running continues.
- Terminal detection uses the next count. If a tick produces count == term, state ← DONE.
- If count already equals term at START, no immediate done is produced. Done occurs only after a full wrap.
- DONE lasts exactly one cycle: done = 1, running = 0, then the state returns to IDLE.
- Ticks in IDLE and DONE are ignored.
- A command and a tick in the same cycle: the command wins and the tick is discarded.
- err changes only on rejected commands (set) and CLEAR (cleared).

## Timing
- All outputs are registered or decoded directly from state; there is no combinational path from inputs to outputs.
- count updates on the clock edge that samples tick, giving 1-cycle latency.
- done and the terminal count value appear after the same edge.
- Command effects are visible the cycle after acceptance.
- rst asserts outputs immediately and asynchronously. Deassertion is synchronous to the design; the first command is accepted on the first edge after release.
- Reset mid-RUN discards term, and count goes to 0.

## Configuration
- BCD_CTRL_DOWN_EN defined: the dir port exists.
  - dir = 1 decrements. A digit at 0 borrows to 9 when all lower digits are 0. 00…0 wraps to 99…9.
  - Terminal detection is identical in both directions.
  - dir is sampled with tick.
- Undefined: no dir port, count up only, and the borrow logic is not compiled.

## Structure
- Package bcd_ctrl_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - cmd_op constants;
  - BCD_W = 4 and BCD_MAX = 9;
  - a function checking that a packed vector contains only valid BCD digits.
- Sub-module bcd_digit, instantiated DIGITS times, provides a single digit with:
  - en and load/load_val;
  - dir (when BCD_CTRL_DOWN_EN is defined);
  - carry_out, meaning at 9 counting up or at 0 counting down.
- The controller chains carry_out from each digit into the next digit's en and owns the FSM, term, and err.

## Test plan
- Reset mid-RUN at count 0457: rst high → immediately count 0000, running 0, done 0, cmd_ready 1. After release, ticks are ignored until START.
- Carry chain: LOAD 0098, START 0102, 4 ticks → count 0099, 0100, 0101, 0102. done is high for exactly one cycle with count 0102, then IDLE with cmd_ready 1.
- Wrap: LOAD 9999, START 0001 → tick gives 0000, tick gives 0001 with done. START 0001 when count is already 0001 → no done until 10000 ticks.
- Illegal operand: LOAD 12A4 → err 1, count unchanged. START F000 → still IDLE. CLEAR → err 0, count 0000.
- Collision: in RUN at 0005, STOP together with tick → count 0005, running 0. LOAD 0010 together with tick in RUN → count 0010.
- BCD_CTRL_DOWN_EN, dir 1: LOAD 0000, START 9998 → tick gives 9999, tick gives 9998 with done. LOAD 0100, tick → 0099.

Source files
------------

// File: rtl/bcd_count_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bcd_ctrl_pkg
// Shared types and constants for the BCD count controller:
//   - state_e : controller FSM states (IDLE, RUN, DONE)
//   - OP_*    : command opcodes carried on cmd_op
//   - BCD_W / BCD_MAX : width and maximum value of one BCD digit
//   - bcd_all_valid() : returns 1 when every nibble of a packed vector is <= 9
// Optional feature macro used elsewhere in this slice: BCD_CTRL_DOWN_EN.
// -----------------------------------------------------------------------------
package bcd_ctrl_pkg;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_START = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  // Operands narrower than MAX_DIGITS are zero-extended by the caller;
  // zero nibbles are legal BCD, so the padding never flags an error.
  function automatic logic bcd_all_valid(input logic [BCD_W*MAX_DIGITS-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[i*BCD_W +: BCD_W] > BCD_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// -----------------------------------------------------------------------------
// bcd_count_ctrl_if
// Command channel of the BCD count controller (valid/ready handshake).
//   cmd_valid : command present (master -> slave)
//   cmd_ready : controller can accept a command (slave -> master)
//   cmd_op    : 00 CLEAR, 01 LOAD, 10 START, 11 STOP
//   cmd_data  : packed BCD operand, digit 0 in [3:0]
// -----------------------------------------------------------------------------
interface bcd_count_ctrl_if #(
  parameter int DIGITS = 4
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [1:0]            cmd_op;
  logic [4*DIGITS-1:0]   cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/bcd_count_ctrl_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One BCD digit (0..9) of the cascaded counter.
//   clk, rst    : clock, asynchronous active-high reset (digit -> 0)
//   en_i        : step this digit on the next edge
//   load_i      : overwrite the digit with load_val_i (has priority over en_i)
//   load_val_i  : value to load
//   dir_i       : 1 = count down (only with BCD_CTRL_DOWN_EN)
//   q_o         : current digit value
//   nxt_o       : value the digit will take on the next edge
//   carry_o     : digit at 9 (up) or at 0 (down); enables the next digit
// Optional feature macro: BCD_CTRL_DOWN_EN.
// -----------------------------------------------------------------------------
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
`ifdef BCD_CTRL_DOWN_EN
  input  logic             dir_i,
`endif
  output logic [BCD_W-1:0] q_o,
  output logic [BCD_W-1:0] nxt_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] step;

  always_comb begin
    step    = '0;
    carry_o = 1'b0;
`ifdef BCD_CTRL_DOWN_EN
    if (dir_i) begin
      step    = (q_q == '0) ? BCD_MAX : q_q - 4'd1;
      carry_o = (q_q == '0);
    end else begin
      step    = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
      carry_o = (q_q == BCD_MAX);
    end
`else
    step    = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    carry_o = (q_q == BCD_MAX);
`endif
    q_d = q_q;
    if (load_i)    q_d = load_val_i;
    else if (en_i) q_d = step;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o   = q_q;
  assign nxt_o = q_d;

endmodule

// File: rtl/bcd_count_ctrl.sv
// -----------------------------------------------------------------------------
// bcd_count_ctrl
// Command-driven controller for a DIGITS-wide cascaded BCD counter.
//   clk, rst  : clock, asynchronous active-high reset
//   cmd       : command channel (bcd_count_ctrl_if.slave)
//   tick_i    : single-cycle count-enable pulse, honoured only in RUN
//   dir_i     : 1 = count down (only with BCD_CTRL_DOWN_EN)
//   count_o   : packed BCD count, digit 0 in [3:0]
//   running_o : high in RUN
//   done_o    : one-cycle pulse after the tick that reaches the terminal value
//   err_o     : sticky illegal-operand flag, cleared by CLEAR
// Optional feature macro: BCD_CTRL_DOWN_EN (adds dir_i and down counting).
// -----------------------------------------------------------------------------
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  bcd_count_ctrl_if.slave     cmd,
  input  logic                tick_i,
`ifdef BCD_CTRL_DOWN_EN
  input  logic                dir_i,
`endif
  output logic [4*DIGITS-1:0] count_o,
  output logic                running_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int W = BCD_W * DIGITS;

  state_e         state_q, state_d;
  logic [W-1:0]   term_q, term_d;
  logic           err_q, err_d;

  logic                        cmd_acc;
  logic                        cmd_ok;
  logic [BCD_W*MAX_DIGITS-1:0] cmd_ext;
  logic                        cnt_en;
  logic                        dig_load;
  logic [W-1:0]                dig_load_val;
  logic [DIGITS-1:0]           dig_en;
  logic [DIGITS-1:0]           carry;
  logic [W-1:0]                cnt_q;
  logic [W-1:0]                cnt_nxt;
  logic                        unused_carry_top;

  assign cmd.cmd_ready = (state_q != DONE);
  assign cmd_acc       = cmd.cmd_valid & cmd.cmd_ready;

  always_comb begin
    cmd_ext          = '0;
    cmd_ext[W-1:0]   = cmd.cmd_data;
    cmd_ok           = bcd_all_valid(cmd_ext);
  end

  // An accepted command takes the cycle; a coincident tick is dropped.
  assign cnt_en = tick_i & (state_q == RUN) & ~cmd_acc;

  // Carry chain: a digit steps when every lower digit is at its wrap value.
  assign dig_en[0] = cnt_en;
  for (genvar i = 1; i < DIGITS; i++) begin : g_chain
    assign dig_en[i] = dig_en[i-1] & carry[i-1];
  end
  assign unused_carry_top = carry[DIGITS-1];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en_i       (dig_en[i]),
      .load_i     (dig_load),
      .load_val_i (dig_load_val[i*BCD_W +: BCD_W]),
`ifdef BCD_CTRL_DOWN_EN
      .dir_i      (dir_i),
`endif
      .q_o        (cnt_q[i*BCD_W +: BCD_W]),
      .nxt_o      (cnt_nxt[i*BCD_W +: BCD_W]),
      .carry_o    (carry[i])
    );
  end

  always_comb begin
    state_d      = state_q;
    term_d       = term_q;
    err_d        = err_q;
    dig_load     = 1'b0;
    dig_load_val = cmd.cmd_data;

    if (state_q == DONE) begin
      state_d = IDLE;
    end else if (cmd_acc) begin
      unique case (cmd.cmd_op)
        OP_CLEAR: begin
          dig_load     = 1'b1;
          dig_load_val = '0;
          err_d        = 1'b0;
          state_d      = IDLE;
        end
        OP_LOAD: begin
          if (cmd_ok) dig_load = 1'b1;
          else        err_d    = 1'b1;
        end
        OP_START: begin
          if (cmd_ok) begin
            term_d  = cmd.cmd_data;
            state_d = RUN;
          end else begin
            err_d   = 1'b1;
          end
        end
        OP_STOP: begin
          if (state_q == RUN) state_d = IDLE;
        end
        default: ;
      endcase
    end else if (cnt_en && (cnt_nxt == term_q)) begin
      // Compare against the post-tick value so done lines up with the count.
      state_d = DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      term_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      err_q   <= err_d;
    end
  end

  assign count_o   = cnt_q;
  assign running_o = (state_q == RUN);
  assign done_o    = (state_q == DONE);
  assign err_o     = err_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
module tb_bcd_count_ctrl;
  import bcd_ctrl_pkg::*;

  localparam int DIGITS = 4;

  typedef struct {
    string       tag;
    logic [15:0] count;
    logic        running;
    logic        done;
    logic        err;
    logic        ready;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0;
`ifdef BCD_CTRL_DOWN_EN
  logic dir = 1'b0;
`endif
  logic [15:0] count;
  logic        running, done, err;

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  bcd_count_ctrl_if #(.DIGITS(DIGITS)) cif ();

  bcd_count_ctrl #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cif),
    .tick_i    (tick),
`ifdef BCD_CTRL_DOWN_EN
    .dir_i     (dir),
`endif
    .count_o   (count),
    .running_o (running),
    .done_o    (done),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".count"},   32'(count),         32'(e.count));
    chk({e.tag, ".running"}, 32'(running),       32'(e.running));
    chk({e.tag, ".done"},    32'(done),          32'(e.done));
    chk({e.tag, ".err"},     32'(err),           32'(e.err));
    chk({e.tag, ".ready"},   32'(cif.cmd_ready), 32'(e.ready));
  endtask

  task automatic push_exp(input string tag, input logic [15:0] c, input logic r,
                          input logic d, input logic e, input logic y);
    exp_t x;
    x.tag = tag; x.count = c; x.running = r; x.done = d; x.err = e; x.ready = y;
    sb.push_back(x);
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs,
  // then compare just after the edge.
  task automatic step(input string tag, input logic v, input logic [1:0] op,
                      input logic [15:0] d, input logic t, input logic [15:0] ec,
                      input logic er, input logic ed, input logic ee, input logic ey);
    cif.cmd_valid = v;
    cif.cmd_op    = op;
    cif.cmd_data  = d;
    tick          = t;
    push_exp(tag, ec, er, ed, ee, ey);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    tick          = 1'b0;
    pop_check();
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_CLEAR;
    cif.cmd_data  = '0;

    // Reset state
    #2;
    push_exp("reset", 16'h0000, 0, 0, 0, 1);
    pop_check();
    @(posedge clk); #1;
    rst = 1'b0;

    // Carry chain
    step("ld98",   1, OP_LOAD,  16'h0098, 0, 16'h0098, 0, 0, 0, 1);
    step("st102",  1, OP_START, 16'h0102, 0, 16'h0098, 1, 0, 0, 1);
    step("t99",    0, OP_CLEAR, 16'h0000, 1, 16'h0099, 1, 0, 0, 1);
    step("t100",   0, OP_CLEAR, 16'h0000, 1, 16'h0100, 1, 0, 0, 1);
    step("t101",   0, OP_CLEAR, 16'h0000, 1, 16'h0101, 1, 0, 0, 1);
    step("t102",   0, OP_CLEAR, 16'h0000, 1, 16'h0102, 0, 1, 0, 0);
    step("postdn", 0, OP_CLEAR, 16'h0000, 1, 16'h0102, 0, 0, 0, 1);
    step("idletk", 0, OP_CLEAR, 16'h0000, 1, 16'h0102, 0, 0, 0, 1);

    // Full wrap
    step("ld9999", 1, OP_LOAD,  16'h9999, 0, 16'h9999, 0, 0, 0, 1);
    step("st0001", 1, OP_START, 16'h0001, 0, 16'h9999, 1, 0, 0, 1);
    step("wrap0",  0, OP_CLEAR, 16'h0000, 1, 16'h0000, 1, 0, 0, 1);
    step("wrap1",  0, OP_CLEAR, 16'h0000, 1, 16'h0001, 0, 1, 0, 0);
    step("wrapid", 0, OP_CLEAR, 16'h0000, 0, 16'h0001, 0, 0, 0, 1);

    // START at the terminal value: done only after 10000 ticks
    step("steq",   1, OP_START, 16'h0001, 0, 16'h0001, 1, 0, 0, 1);
    for (int i = 1; i < 10000; i++)
      step("lap", 0, OP_CLEAR, 16'h0000, 1, to_bcd((1 + i) % 10000), 1, 0, 0, 1);
    step("lapend", 0, OP_CLEAR, 16'h0000, 1, 16'h0001, 0, 1, 0, 0);
    step("lapid",  0, OP_CLEAR, 16'h0000, 0, 16'h0001, 0, 0, 0, 1);

    // Illegal operands
    step("ldbad",  1, OP_LOAD,  16'h12A4, 0, 16'h0001, 0, 0, 1, 1);
    step("stbad",  1, OP_START, 16'hF000, 0, 16'h0001, 0, 0, 1, 1);
    step("badtk",  0, OP_CLEAR, 16'h0000, 1, 16'h0001, 0, 0, 1, 1);
    step("clr",    1, OP_CLEAR, 16'h5555, 0, 16'h0000, 0, 0, 0, 1);

    // Reset in the middle of RUN
    step("ld457",  1, OP_LOAD,  16'h0457, 0, 16'h0457, 0, 0, 0, 1);
    step("st999",  1, OP_START, 16'h0999, 0, 16'h0457, 1, 0, 0, 1);
    step("ldbad2", 1, OP_LOAD,  16'h00B0, 0, 16'h0457, 1, 0, 1, 1);
    #2;
    rst = 1'b1;
    #1;
    push_exp("rstrun", 16'h0000, 0, 0, 0, 1);
    pop_check();
    @(posedge clk); #1;
    rst = 1'b0;
    step("rsttk",  0, OP_CLEAR, 16'h0000, 1, 16'h0000, 0, 0, 0, 1);
    step("rsttk2", 0, OP_CLEAR, 16'h0000, 1, 16'h0000, 0, 0, 0, 1);

    // Command / tick collisions and RUN-time commands
    step("st100",  1, OP_START, 16'h0100, 0, 16'h0000, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++)
      step("run5", 0, OP_CLEAR, 16'h0000, 1, to_bcd(i), 1, 0, 0, 1);
    step("stoptk", 1, OP_STOP,  16'h0000, 1, 16'h0005, 0, 0, 0, 1);
    step("stopid", 1, OP_STOP,  16'h0000, 0, 16'h0005, 0, 0, 0, 1);
    step("st100b", 1, OP_START, 16'h0100, 0, 16'h0005, 1, 0, 0, 1);
    step("ldtk",   1, OP_LOAD,  16'h0010, 1, 16'h0010, 1, 0, 0, 1);
    step("t11",    0, OP_CLEAR, 16'h0000, 1, 16'h0011, 1, 0, 0, 1);
    step("rest13", 1, OP_START, 16'h0013, 0, 16'h0011, 1, 0, 0, 1);
    step("t12",    0, OP_CLEAR, 16'h0000, 1, 16'h0012, 1, 0, 0, 1);
    step("t13",    0, OP_CLEAR, 16'h0000, 1, 16'h0013, 0, 1, 0, 0);
    step("dncmd",  1, OP_CLEAR, 16'h0000, 0, 16'h0013, 0, 0, 0, 1);
    step("st50",   1, OP_START, 16'h0050, 0, 16'h0013, 1, 0, 0, 1);
    step("t14",    0, OP_CLEAR, 16'h0000, 1, 16'h0014, 1, 0, 0, 1);
    step("clrrun", 1, OP_CLEAR, 16'h0000, 1, 16'h0000, 0, 0, 0, 1);

`ifdef BCD_CTRL_DOWN_EN
    // Down counting
    dir = 1'b1;
    step("dld0",   1, OP_LOAD,  16'h0000, 0, 16'h0000, 0, 0, 0, 1);
    step("dst",    1, OP_START, 16'h9998, 0, 16'h0000, 1, 0, 0, 1);
    step("d9999",  0, OP_CLEAR, 16'h0000, 1, 16'h9999, 1, 0, 0, 1);
    step("d9998",  0, OP_CLEAR, 16'h0000, 1, 16'h9998, 0, 1, 0, 0);
    step("didle",  0, OP_CLEAR, 16'h0000, 0, 16'h9998, 0, 0, 0, 1);
    step("dld100", 1, OP_LOAD,  16'h0100, 0, 16'h0100, 0, 0, 0, 1);
    step("dst50",  1, OP_START, 16'h0050, 0, 16'h0100, 1, 0, 0, 1);
    step("d0099",  0, OP_CLEAR, 16'h0000, 1, 16'h0099, 1, 0, 0, 1);
    step("dstop",  1, OP_STOP,  16'h0000, 0, 16'h0099, 0, 0, 0, 1);
    dir = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
